// File: rtl/word_stacker_if.sv
// word_stacker_if: word-in / block-out handshake bundle between the streamer and the AES core input
interface word_stacker_if #(
    parameter int IN_WIDTH  = 32,
    parameter int NUM_WORDS = 4
);
    logic                          valid_i;
    logic                          ready_o;
    logic [IN_WIDTH-1:0]           word_i;
    logic                          valid_o;
    logic                          ready_i;
    logic [IN_WIDTH*NUM_WORDS-1:0] word_o;
    modport master (output valid_i, word_i, ready_i, input ready_o, valid_o, word_o);
    modport slave  (input valid_i, word_i, ready_i, output ready_o, valid_o, word_o);
endinterface

// File: rtl/word_stacker.sv
// word_stacker: packs NUM_WORDS input words into one block, first word in the top slice; WORD_STACKER_DOUBLE_BUF_EN adds a separate assembly register
module word_stacker #(
    parameter int IN_WIDTH  = 32,
    parameter int NUM_WORDS = 4
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          clr_i,
    input  logic          enable_i,
    word_stacker_if.slave bus
);
    localparam int CW = $clog2(NUM_WORDS);
    localparam int BW = IN_WIDTH * NUM_WORDS;

    logic [CW-1:0] cnt_q, cnt_d;
    logic          accept, pop, last;

    function automatic logic [BW-1:0] put(input logic [BW-1:0] blk, input logic [CW-1:0] k,
                                          input logic [IN_WIDTH-1:0] w);
        logic [BW-1:0] r;
        r = blk;
        for (int i = 0; i < NUM_WORDS; i++)
            if (k == CW'(i)) r[(NUM_WORDS-1-i)*IN_WIDTH +: IN_WIDTH] = w;
        return r;
    endfunction

    assign accept = enable_i & bus.valid_i & bus.ready_o;
    assign pop    = enable_i & bus.valid_o & bus.ready_i;
    assign last   = accept & (cnt_q == CW'(NUM_WORDS-1));
    assign cnt_d  = last ? '0 : cnt_q + CW'(accept);

`ifdef WORD_STACKER_DOUBLE_BUF_EN
    logic [BW-1:0] asm_q, asm_d, out_q, out_d, blk;
    logic          asm_full_q, asm_full_d, out_full_q, out_full_d, direct;

    assign bus.ready_o = ~asm_full_q;
    assign bus.valid_o = out_full_q;
    assign bus.word_o  = out_q;

    // completed block goes straight to the output when it is free or being popped, else parks in assembly
    always_comb begin
        blk        = put(asm_q, cnt_q, bus.word_i);
        direct     = last & (~out_full_q | pop);
        asm_d      = accept ? blk : asm_q;
        out_d      = direct ? blk : (asm_full_q & pop) ? asm_q : out_q;
        asm_full_d = (last & ~direct) | (asm_full_q & ~pop);
        out_full_d = direct | (asm_full_q & pop) | (out_full_q & ~pop);
    end

    // assembly, output and occupancy registers
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q      <= '0;
            asm_q      <= '0;
            out_q      <= '0;
            asm_full_q <= 1'b0;
            out_full_q <= 1'b0;
        end else if (clr_i) begin
            cnt_q      <= '0;
            asm_q      <= '0;
            out_q      <= '0;
            asm_full_q <= 1'b0;
            out_full_q <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            asm_q      <= asm_d;
            out_q      <= out_d;
            asm_full_q <= asm_full_d;
            out_full_q <= out_full_d;
        end
    end
`else
    typedef enum logic {COLLECT, FULL} state_t;

    state_t        state_q, state_d;
    logic [BW-1:0] data_q, data_d;

    assign bus.ready_o = state_q == COLLECT;
    assign bus.valid_o = state_q == FULL;
    assign bus.word_o  = data_q;

    // collect until the last slice is written, then hold the block until it is popped
    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        state_d = last ? FULL : pop ? COLLECT : state_q;
        data_d  = accept ? put(data_q, cnt_q, bus.word_i) : data_q;
    end

    // state, slice counter and shared data register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= COLLECT;
            cnt_q   <= '0;
            data_q  <= '0;
        end else if (clr_i) begin
            state_q <= COLLECT;
            cnt_q   <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
        end
    end
`endif
endmodule
